// File: rtl/data_mem_responder.sv
// Load/store memory responder: accepts one request at a time, spends a fixed
// number of wait cycles, then returns load data or an error under valid/ready.
module data_mem_responder #(
    parameter int unsigned ADDR_WIDTH  = 8,
    parameter int unsigned WAIT_STATES = 2
) (
    input  logic        Clock,
    input  logic        Reset_n,
    input  logic        Req_Valid,
    output logic        Req_Ready,
    input  logic        Req_Write,
    input  logic [15:0] Req_Addr,
    input  logic [15:0] Req_WData,
    output logic        Resp_Valid,
    input  logic        Resp_Ready,
    output logic [15:0] Resp_RData,
    output logic        Resp_Err
);

    localparam int unsigned DATA_W = 16;
    localparam int unsigned DEPTH  = 2 ** ADDR_WIDTH;
    localparam int unsigned CNT_W  = (WAIT_STATES < 2) ? 1 : $clog2(WAIT_STATES + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef struct packed {
        logic              write;
        logic [DATA_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } req_t;

    state_t              state;
    state_t              state_next;
    logic [CNT_W-1:0]    cnt;
    logic [CNT_W-1:0]    cnt_next;
    req_t                req_q;
    logic [DATA_W-1:0]   mem [DEPTH];

    logic                accept_c;
    logic                enter_resp_c;
    logic                resp_done_c;
    logic                err_c;
    logic                mem_we_c;
    logic [ADDR_WIDTH-1:0] index_c;

    // Latched-address decode: misaligned, or any byte-address bit above the array.
    always_comb begin
        err_c    = req_q.addr[0] | ((req_q.addr >> (ADDR_WIDTH + 1)) != '0);
        index_c  = req_q.addr[ADDR_WIDTH:1];
        mem_we_c = enter_resp_c & req_q.write & ~err_c;
    end

    // Next-state logic; the RESP-entry edge follows the last wait cycle.
    always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        accept_c     = 1'b0;
        enter_resp_c = 1'b0;
        resp_done_c  = 1'b0;
        unique case (state)
            IDLE: begin
                if (Req_Valid && Req_Ready) begin
                    accept_c   = 1'b1;
                    cnt_next   = CNT_W'(WAIT_STATES);
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (cnt == '0) begin
                    enter_resp_c = 1'b1;
                    state_next   = RESP;
                end else begin
                    cnt_next = cnt - CNT_W'(1);
                end
            end
            RESP: begin
                if (Resp_Ready) begin
                    resp_done_c = 1'b1;
                    state_next  = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State, latched request and registered handshake/response outputs.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state      <= IDLE;
            cnt        <= '0;
            req_q      <= '0;
            Req_Ready  <= 1'b1;
            Resp_Valid <= 1'b0;
            Resp_RData <= '0;
            Resp_Err   <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (accept_c) begin
                req_q     <= '{write: Req_Write, addr: Req_Addr, wdata: Req_WData};
                Req_Ready <= 1'b0;
            end
            if (enter_resp_c) begin
                Resp_Valid <= 1'b1;
                Resp_Err   <= err_c;
                Resp_RData <= (err_c || req_q.write) ? '0 : mem[index_c];
            end
            if (resp_done_c) begin
                Resp_Valid <= 1'b0;
                Resp_Err   <= 1'b0;
                Req_Ready  <= 1'b1;
            end
        end
    end

    // Storage is not reset; a store commits only on its RESP-entry edge.
    always_ff @(posedge Clock) begin
        if (mem_we_c) begin
            mem[index_c] <= req_q.wdata;
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: table-driven requests through two instances
// (2 wait states and 0 wait states) with a response scoreboard queue.
module tb_data_mem_responder;

    logic        Clock = 1'b0;
    logic        Reset_n;
    logic        sel;
    logic        req_valid;
    logic        req_write;
    logic [15:0] req_addr;
    logic [15:0] req_wdata;
    logic        resp_ready;

    logic        a_req_ready, a_resp_valid, a_resp_err;
    logic [15:0] a_resp_rdata;
    logic        b_req_ready, b_resp_valid, b_resp_err;
    logic [15:0] b_resp_rdata;

    logic        req_ready, resp_valid, resp_err;
    logic [15:0] resp_rdata;

    typedef struct {
        logic        write;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    typedef struct {
        logic [15:0] rdata;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 Clock = ~Clock;

    assign req_ready  = sel ? b_req_ready  : a_req_ready;
    assign resp_valid = sel ? b_resp_valid : a_resp_valid;
    assign resp_err   = sel ? b_resp_err   : a_resp_err;
    assign resp_rdata = sel ? b_resp_rdata : a_resp_rdata;

    data_mem_responder #(.ADDR_WIDTH(8), .WAIT_STATES(2)) dut_a (
        .Clock      (Clock),
        .Reset_n    (Reset_n),
        .Req_Valid  (req_valid & ~sel),
        .Req_Ready  (a_req_ready),
        .Req_Write  (req_write),
        .Req_Addr   (req_addr),
        .Req_WData  (req_wdata),
        .Resp_Valid (a_resp_valid),
        .Resp_Ready (resp_ready & ~sel),
        .Resp_RData (a_resp_rdata),
        .Resp_Err   (a_resp_err)
    );

    data_mem_responder #(.ADDR_WIDTH(8), .WAIT_STATES(0)) dut_b (
        .Clock      (Clock),
        .Reset_n    (Reset_n),
        .Req_Valid  (req_valid & sel),
        .Req_Ready  (b_req_ready),
        .Req_Write  (req_write),
        .Req_Addr   (req_addr),
        .Req_WData  (req_wdata),
        .Resp_Valid (b_resp_valid),
        .Resp_Ready (resp_ready & sel),
        .Resp_RData (b_resp_rdata),
        .Resp_Err   (b_resp_err)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"},  32'(req_ready),  32'd1);
        check({tag, "_resp_valid"}, 32'(resp_valid), 32'd0);
        check({tag, "_resp_rdata"}, 32'(resp_rdata), 32'd0);
        check({tag, "_resp_err"},   32'(resp_err),   32'd0);
    endtask

    // One request: accept, measure latency, score the response, optionally
    // hold Resp_Ready low for 'hold' cycles while an ignored request is offered.
    task automatic do_req(input logic w, input logic [15:0] a, input logic [15:0] d,
                          input logic [15:0] er, input logic ee, input int lat, input int hold);
        int   cyc;
        exp_t e;
        @(negedge Clock);
        req_write  = w;
        req_addr   = a;
        req_wdata  = d;
        req_valid  = 1'b1;
        resp_ready = (hold == 0);
        cyc = 0;
        while (!req_ready && cyc < 20) begin
            @(negedge Clock);
            cyc++;
        end
        check("accept", 32'(req_ready), 32'd1);
        exp_q.push_back('{rdata: er, err: ee});
        @(posedge Clock);
        #1;
        req_valid = 1'b0;
        check("req_ready_busy", 32'(req_ready), 32'd0);
        cyc = 0;
        while (!resp_valid && cyc < 50) begin
            @(posedge Clock);
            #1;
            cyc++;
        end
        check("latency", 32'(cyc), 32'(lat));
        if (exp_q.size() == 0) begin
            check("scoreboard_empty", 32'd0, 32'd1);
            return;
        end
        e = exp_q.pop_front();
        check("resp_rdata", 32'(resp_rdata), 32'(e.rdata));
        check("resp_err",   32'(resp_err),   32'(e.err));
        for (int i = 0; i < hold; i++) begin
            req_valid = 1'b1;
            req_write = 1'b1;
            req_addr  = 16'h0004;
            req_wdata = 16'hDEAD;
            @(posedge Clock);
            #1;
            check("bp_resp_valid", 32'(resp_valid), 32'd1);
            check("bp_resp_rdata", 32'(resp_rdata), 32'(e.rdata));
            check("bp_req_ready",  32'(req_ready),  32'd0);
        end
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        @(posedge Clock);
        #1;
        check("resp_valid_drop", 32'(resp_valid), 32'd0);
        check("resp_err_clear",  32'(resp_err),   32'd0);
        check("resp_rdata_hold", 32'(resp_rdata), 32'(e.rdata));
        check("req_ready_back",  32'(req_ready),  32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t va[10];
        vec_t vb[5];

        va[0] = '{1'b1, 16'h0004, 16'hBEEF, 16'h0000, 1'b0};
        va[1] = '{1'b0, 16'h0004, 16'h0000, 16'hBEEF, 1'b0};
        va[2] = '{1'b1, 16'h0005, 16'h1234, 16'h0000, 1'b1};
        va[3] = '{1'b0, 16'h0004, 16'h0000, 16'hBEEF, 1'b0};
        va[4] = '{1'b0, 16'h0200, 16'h0000, 16'h0000, 1'b1};
        va[5] = '{1'b1, 16'h01FE, 16'h7E7E, 16'h0000, 1'b0};
        va[6] = '{1'b0, 16'h01FE, 16'h0000, 16'h7E7E, 1'b0};
        va[7] = '{1'b1, 16'h0008, 16'h5555, 16'h0000, 1'b0};
        va[8] = '{1'b1, 16'h8000, 16'h1111, 16'h0000, 1'b1};
        va[9] = '{1'b0, 16'h0008, 16'h0000, 16'h5555, 1'b0};

        vb[0] = '{1'b1, 16'h0004, 16'hCAFE, 16'h0000, 1'b0};
        vb[1] = '{1'b0, 16'h0004, 16'h0000, 16'hCAFE, 1'b0};
        vb[2] = '{1'b0, 16'h0003, 16'h0000, 16'h0000, 1'b1};
        vb[3] = '{1'b1, 16'h0002, 16'h0101, 16'h0000, 1'b0};
        vb[4] = '{1'b0, 16'h0002, 16'h0000, 16'h0101, 1'b0};

        Reset_n    = 1'b0;
        sel        = 1'b0;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_addr   = '0;
        req_wdata  = '0;
        resp_ready = 1'b1;

        repeat (3) @(posedge Clock);
        #1;
        check_reset_outputs("rst_a");
        sel = 1'b1;
        #1;
        check_reset_outputs("rst_b");
        sel = 1'b0;
        @(negedge Clock);
        Reset_n = 1'b1;

        // Two wait states: three cycles from accept to response.
        for (int i = 0; i < 10; i++) begin
            do_req(va[i].write, va[i].addr, va[i].wdata, va[i].exp_rdata, va[i].exp_err, 3, 0);
        end

        // Backpressure on a load; the store offered meanwhile must be ignored.
        do_req(1'b0, 16'h0004, 16'h0000, 16'hBEEF, 1'b0, 3, 5);
        do_req(1'b0, 16'h0004, 16'h0000, 16'hBEEF, 1'b0, 3, 0);

        // Reset during WAIT of a store: outputs clear, store never commits.
        @(negedge Clock);
        req_write  = 1'b1;
        req_addr   = 16'h0008;
        req_wdata  = 16'hAAAA;
        req_valid  = 1'b1;
        resp_ready = 1'b1;
        check("midop_accept", 32'(req_ready), 32'd1);
        @(posedge Clock);
        #1;
        req_valid = 1'b0;
        @(posedge Clock);
        #1;
        check("midop_busy", 32'(req_ready), 32'd0);
        Reset_n = 1'b0;
        #1;
        check_reset_outputs("midop_rst");
        @(negedge Clock);
        Reset_n = 1'b1;
        do_req(1'b0, 16'h0008, 16'h0000, 16'h5555, 1'b0, 3, 0);

        // Zero wait states: response one cycle after accept.
        @(negedge Clock);
        sel = 1'b1;
        for (int i = 0; i < 5; i++) begin
            do_req(vb[i].write, vb[i].addr, vb[i].wdata, vb[i].exp_rdata, vb[i].exp_err, 1, 0);
        end

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
